// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared FSM state type and bit-reverse helper for the twiddle index sequencer
package twiddle_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} twseq_state_t;
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[i] = v[width-1-i];
    return r;
  endfunction
endpackage

// File: rtl/twiddle_idx_seq_if.sv
// twiddle_idx_seq_if: valid/ready index stream (idx_valid, idx_ready, idx_out, row_out, col_out, last_col, last_row); master = sequencer, slave = twiddle ROM side
interface twiddle_idx_seq_if #(parameter int WIDTH = 3);
  logic idx_valid;
  logic idx_ready;
  logic last_col;
  logic last_row;
  logic [WIDTH-1:0] idx_out;
  logic [WIDTH-1:0] row_out;
  logic [WIDTH-1:0] col_out;
  modport master(output idx_valid, idx_out, row_out, col_out, last_col, last_row, input idx_ready);
  modport slave(input idx_valid, idx_out, row_out, col_out, last_col, last_row, output idx_ready);
endinterface

// File: rtl/twiddle_idx_seq_indexmod.sv
// indexmod: parallel S[j] = a*j mod N for j = 0..N-1 (ports: a in, s out); N a power of two so truncation is the mod
module indexmod #(
  parameter int N = 8,
  parameter int WIDTH = $clog2(N)
) (
  input  logic [WIDTH-1:0]        a,
  output logic [N-1:0][WIDTH-1:0] s
);
  for (genvar j = 0; j < N; j++) begin : g_mul
    assign s[j] = a * WIDTH'(j);
  end
endmodule

// File: rtl/twiddle_idx_seq.sv
// twiddle_idx_seq: sweeps every row of an N-point twiddle matrix, streaming (row, col, row*col mod N) over bus.
// Ports: clk, rst_n (async active-low), start pulse in, busy/done out, bus = twiddle_idx_seq_if.master.
// Build option: define TWIDDLE_BITREV_EN to visit rows in bit-reversed order.
module twiddle_idx_seq
  import twiddle_pkg::*;
#(
  parameter int N = 8,
  parameter int WIDTH = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  twiddle_idx_seq_if.master bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);
  twseq_state_t state, next;
  logic [WIDTH-1:0] row, col, row_vis;
  logic [N-1:0][WIDTH-1:0] bank, prod;
  logic xfer;
`ifdef TWIDDLE_BITREV_EN
  assign row_vis = WIDTH'(bitrev(16'(row), WIDTH));
`else
  assign row_vis = row;
`endif
  indexmod #(.N(N), .WIDTH(WIDTH)) u_indexmod (.a(row_vis), .s(prod));
  assign xfer = state == STREAM && bus.idx_ready;
  // Outputs are gated by valid so every field reads zero outside STREAM
  always_comb begin
    next = state == IDLE   ? (start ? LOAD : IDLE) :
           state == LOAD   ? STREAM :
           state == STREAM ? (xfer && col == MAX ? (row == MAX ? FIN : LOAD) : STREAM) :
                             IDLE;
    busy          = state == LOAD || state == STREAM;
    done          = state == FIN;
    bus.idx_valid = state == STREAM;
    bus.idx_out   = bus.idx_valid ? bank[col] : '0;
    bus.row_out   = bus.idx_valid ? row_vis : '0;
    bus.col_out   = bus.idx_valid ? col : '0;
    bus.last_col  = bus.idx_valid && col == MAX;
    bus.last_row  = bus.idx_valid && row == MAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      bank  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) row <= '0;
      if (state == LOAD) begin
        bank <= prod;
        col  <= '0;
      end
      // Row counter wraps back to 0 after the final row
      if (xfer) begin
        col <= col == MAX ? '0 : col + 1'b1;
        if (col == MAX) row <= row + 1'b1;
      end
    end
  end
endmodule
